freq_synth_nco: RTL

- Programmable square-wave source: the stimulus end of the frequency-measurement path.
- Takes a requested frequency in Hz over a valid/ready handshake.
- Converts it to a phase-accumulator tuning word with an iterative divider.
- Drives a square wave for the measurement block to count. The new frequency takes effect at an accumulator wrap, so the output never has a runt pulse.

---
 rtl/freq_synth_nco.sv | 105 ++++++++++
 1 files changed

// File: rtl/freq_synth_nco.sv
// Programmable square-wave source: a requested frequency in Hz is turned into a
// phase-accumulator tuning word by a restoring divider and swapped in at a wrap.
module freq_synth_nco #(
  parameter int CLK_STAND_FREQ = 100000000,
  parameter int ACC_W          = 32,
  parameter int FREQ_W         = 28
) (
  input  logic              clk_stand,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              freq_valid,
  output logic              freq_ready,
  output logic              freq_err,
  output logic              wave_out,
  output logic              tick,
  output logic [ACC_W-1:0]  tw_cur
);

  typedef enum logic [1:0] {IDLE, DIV, WAIT_WRAP} state_t;

  localparam int                CNT_W     = $clog2(ACC_W) + 1;
  localparam logic [FREQ_W+1:0] DIVISOR   = (FREQ_W+2)'(CLK_STAND_FREQ);
  localparam logic [FREQ_W-1:0] FREQ_MAX  = FREQ_W'(CLK_STAND_FREQ / 2);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(ACC_W - 1);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   tw_new;
  logic [FREQ_W:0]    rem;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic [FREQ_W+1:0]  rem_sh;
  logic [FREQ_W:0]    rem_nx;
  logic               q_bit;
  logic               accept;

  always_comb begin
    sum    = {1'b0, acc} + {1'b0, tw_cur};
    carry  = sum[ACC_W];
    rem_sh = {rem, 1'b0};
    q_bit  = (rem_sh >= DIVISOR);
    rem_nx = q_bit ? (FREQ_W+1)'(rem_sh - DIVISOR) : rem_sh[FREQ_W:0];
    accept = freq_valid && freq_ready;
  end

  // The MSB of the accumulator is the square wave; carry-out marks one period.
  assign wave_out = acc[ACC_W-1];

  always_ff @(posedge clk_stand or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      freq_ready <= 1'b1;
      freq_err   <= 1'b0;
      tick       <= 1'b0;
      acc        <= '0;
      tw_cur     <= '0;
      cnt        <= '0;
    end else begin
      acc      <= sum[ACC_W-1:0];
      tick     <= carry;
      freq_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (freq_in > FREQ_MAX) begin
              freq_err <= 1'b1;
            end else begin
              state      <= DIV;
              freq_ready <= 1'b0;
              cnt        <= '0;
            end
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= WAIT_WRAP;
        end
        WAIT_WRAP: begin
          // Swap only on a carry so the running half-period is never cut short.
          if (carry || (tw_cur == '0)) begin
            tw_cur     <= tw_new;
            state      <= IDLE;
            freq_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          freq_ready <= 1'b1;
        end
      endcase
    end
  end

  // Restoring divider: one quotient bit per cycle, MSB first.
  always_ff @(posedge clk_stand) begin
    if (state == IDLE && accept) begin
      rem <= {1'b0, freq_in};
    end else if (state == DIV) begin
      rem    <= rem_nx;
      tw_new <= {tw_new[ACC_W-2:0], q_bit};
    end
  end

endmodule
